// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the RV32I multi-cycle controller
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_MISALIGN = 2'd2,
        TRAP_TIMEOUT  = 2'd3
    } trap_cause_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction and data memory handshake bundle for cpu_ctrl
interface cpu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_ctrl_pc.sv
// rtl/cpu_ctrl_pc.sv - PC register, next-PC select/increment and target alignment check
module cpu_ctrl_pc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            take_tgt,
    input  logic [XLEN-1:0] tgt_addr,
    input  logic            latch_next,
    input  logic            load_now,
    input  logic            load_saved,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] saved_pc;

    // Next PC: jump/taken-branch target or sequential pc+4 (wraps at 2^XLEN)
    always_comb begin
        next_pc    = take_tgt ? tgt_addr : pc + XLEN'(4);
        misaligned = take_tgt && (tgt_addr[1:0] != 2'b00);
    end

    // PC update; the target is only valid in EXEC, so it is saved for MEM/WB commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            saved_pc <= RESET_PC;
        end else begin
            if (latch_next) begin
                saved_pc <= next_pc;
            end
            if (load_now) begin
                pc <= next_pc;
            end else if (load_saved) begin
                pc <= saved_pc;
            end
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle RV32I sequencer (FSM, IR, wait counter); perf counters under CPU_CTRL_PERF_EN
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter int              MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_ctrl_if.master         bus,
    output logic [31:0]        ir,
    output logic [XLEN-1:0]    pc,
    input  logic               is_i_instr,
    input  logic               is_s_instr,
    input  logic               is_r_instr,
    input  logic               is_u_instr,
    input  logic               is_b_instr,
    input  logic               is_j_instr,
    input  logic               is_load,
    input  logic               is_jal,
    input  logic               is_jalr,
    input  logic               wr_en,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    tgt_addr,
    output logic               rf_we,
    output logic               retire,
    output logic               halted,
    output logic [1:0]         trap_cause,
    output logic [63:0]        cycle_cnt,
    output logic [63:0]        instret_cnt
);

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    ctrl_state_t state, state_d;
    trap_cause_t trap_q, trap_d;
    logic [15:0] wait_cnt;
    logic        wait_last;
    logic        legal, take_tgt, mem_op, misaligned;
    logic        imem_req_c, dmem_req_c, rf_we_c, retire_c;
    logic        ir_load, latch_next, load_now, load_saved;

    assign legal     = is_i_instr | is_s_instr | is_r_instr | is_u_instr | is_b_instr | is_j_instr;
    assign take_tgt  = (is_b_instr && br_taken) || is_jal || is_jalr;
    assign mem_op    = is_load || is_s_instr;
    assign wait_last = (wait_cnt == WAIT_LAST);

    cpu_ctrl_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .take_tgt   (take_tgt),
        .tgt_addr   (tgt_addr),
        .latch_next (latch_next),
        .load_now   (load_now),
        .load_saved (load_saved),
        .pc         (pc),
        .misaligned (misaligned)
    );

    // Next-state and per-state strobes; TRAP holds everything idle until reset
    always_comb begin
        state_d    = state;
        trap_d     = trap_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        ir_load    = 1'b0;
        latch_next = 1'b0;
        load_now   = 1'b0;
        load_saved = 1'b0;
        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (wait_last) begin
                    state_d = TRAP;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            DECODE: begin
                if (!legal) begin
                    state_d = TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                latch_next = 1'b1;
                if (misaligned) begin
                    state_d = TRAP;
                    trap_d  = TRAP_MISALIGN;
                end else if (mem_op) begin
                    state_d = MEM;
                end else if (wr_en) begin
                    state_d = WB;
                end else begin
                    load_now = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                if (bus.dmem_ack) begin
                    if (is_s_instr) begin
                        load_saved = 1'b1;
                        retire_c   = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_last) begin
                    state_d = TRAP;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            WB: begin
                rf_we_c    = wr_en;
                load_saved = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, IR, trap cause and memory wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            trap_q   <= TRAP_NONE;
            ir       <= NOP_INSTR;
            wait_cnt <= '0;
        end else begin
            state  <= state_d;
            trap_q <= trap_d;
            if (ir_load) begin
                ir <= bus.imem_rdata;
            end
            if ((state_d != state) && (state_d == FETCH || state_d == MEM)) begin
                wait_cnt <= '0;
            end else if ((state == FETCH && !bus.imem_ack) || (state == MEM && !bus.dmem_ack)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // Reset gates every request and strobe combinationally so an abort is immediate
    assign bus.imem_req  = imem_req_c & rst_n;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = dmem_req_c & rst_n;
    assign bus.dmem_we   = dmem_req_c & rst_n & is_s_instr;
    assign rf_we         = rf_we_c & rst_n;
    assign retire        = retire_c & rst_n;
    assign halted        = (state == TRAP);
    assign trap_cause    = trap_q;

`ifdef CPU_CTRL_PERF_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    // Free-running cycle count and retired-instruction count, both wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (retire_c) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 64'd0;
    assign instret_cnt = 64'd0;
`endif

endmodule
